// File: rtl/ecc_bus_sequencer.sv
// ecc_bus_sequencer
//   Sequences one MCU access at a time onto the ECC bridge. A legal request
//   walks through SETUP (direction + ECC code settle, chips deselected),
//   ACCESS (chips selected) and TURN (chips deselected, bus back to read)
//   before the next request can be accepted. An illegal ECC code (2'b11)
//   gets a one-cycle error response and never touches the bus.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (transfer on valid & ready)
//   req_write, req_ecc     request attributes, sampled on the accept edge only
//   rsp_valid, rsp_err     one-cycle completion pulse and its error flag
//   rd_capture             one-cycle pulse in the last ACCESS cycle of a read
//   write_en, chip_sel,    bridge controls (write_en 0 = write direction,
//   ecc_sel                chip_sel 2'b00 = selected, 2'b11 = deselected)
//
// Every output comes straight from a flop; the next-cycle values are built
// in always_comb from the next state so outputs line up with the state.

module ecc_bus_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 2,
    parameter int TURN_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_ecc,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic       rd_capture,
    output logic       write_en,
    output logic [1:0] chip_sel,
    output logic [1:0] ecc_sel
);

    localparam int MAX_SA  = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
    localparam int MAX_CYC = (MAX_SA > TURN_CYC) ? MAX_SA : TURN_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_TWO    = CW'(2);
    localparam logic [CW-1:0] CNT_SETUP  = CW'(SETUP_CYC);
    localparam logic [CW-1:0] CNT_ACCESS = CW'(ACCESS_CYC);
    localparam logic [CW-1:0] CNT_TURN   = CW'(TURN_CYC);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, TURN, ERR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rd_capture_q, rd_capture_d;
    logic          write_en_q, write_en_d;
    logic [1:0]    chip_sel_q, chip_sel_d;
    logic [1:0]    ecc_sel_q, ecc_sel_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        req_ready_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rd_capture_d = 1'b0;
        write_en_d   = write_en_q;
        chip_sel_d   = chip_sel_q;
        ecc_sel_d    = ecc_sel_q;
        case (state_q)
            IDLE: begin
                // req_ready_q is low for the first cycle out of reset, so a
                // held req_valid is not taken until the sequencer advertises.
                if (req_valid && req_ready_q) begin
                    wr_d = req_write;
                    if (req_ecc == 2'b11) begin
                        state_d     = ERR;
                        cnt_d       = CNT_ONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = SETUP;
                        cnt_d      = CNT_SETUP;
                        ecc_sel_d  = req_ecc;
                        write_en_d = ~req_write;
                        chip_sel_d = 2'b11;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d    = ACCESS;
                    cnt_d      = CNT_ACCESS;
                    chip_sel_d = 2'b00;
                    // single-cycle access: the first ACCESS cycle is also the last
                    rd_capture_d = !wr_q && (ACCESS_CYC == 1);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_ONE) begin
                    // deselect and release the bus on the same edge; write_en
                    // moving here is safe because chip_sel leaves 00 with it
                    state_d     = TURN;
                    cnt_d       = CNT_TURN;
                    chip_sel_d  = 2'b11;
                    write_en_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d        = cnt_q - CNT_ONE;
                    rd_capture_d = !wr_q && (ACCESS_CYC > 1) && (cnt_q == CNT_TWO);
                end
            end
            TURN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    req_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ERR: begin
                state_d     = IDLE;
                cnt_d       = '0;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                chip_sel_d  = 2'b11;
                write_en_d  = 1'b1;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rd_capture_q <= 1'b0;
            write_en_q   <= 1'b1;
            chip_sel_q   <= 2'b11;
            ecc_sel_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rd_capture_q <= rd_capture_d;
            write_en_q   <= write_en_d;
            chip_sel_q   <= chip_sel_d;
            ecc_sel_q    <= ecc_sel_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rd_capture = rd_capture_q;
    assign write_en   = write_en_q;
    assign chip_sel   = chip_sel_q;
    assign ecc_sel    = ecc_sel_q;

endmodule

// File: tb/tb_ecc_bus_sequencer.sv
// Bench for ecc_bus_sequencer. Two instances share the request inputs: one
// with default timing, one with a 3-cycle access phase. The reference model
// turns each accepted request into the list of per-cycle output vectors it
// should produce; with nothing queued the bus is expected idle.

module tb_ecc_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_write;
    logic [1:0] req_ecc;

    logic       o_ready [2];
    logic       o_rv    [2];
    logic       o_re    [2];
    logic       o_rc    [2];
    logic       o_we    [2];
    logic [1:0] o_cs    [2];
    logic [1:0] o_ecc   [2];

    always #5 clk = ~clk;

    ecc_bus_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(o_ready[0]),
        .req_write(req_write), .req_ecc(req_ecc), .rsp_valid(o_rv[0]),
        .rsp_err(o_re[0]), .rd_capture(o_rc[0]), .write_en(o_we[0]),
        .chip_sel(o_cs[0]), .ecc_sel(o_ecc[0])
    );

    ecc_bus_sequencer #(.SETUP_CYC(1), .ACCESS_CYC(3), .TURN_CYC(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(o_ready[1]),
        .req_write(req_write), .req_ecc(req_ecc), .rsp_valid(o_rv[1]),
        .rsp_err(o_re[1]), .rd_capture(o_rc[1]), .write_en(o_we[1]),
        .chip_sel(o_cs[1]), .ecc_sel(o_ecc[1])
    );

    typedef struct packed {
        logic       ready;
        logic       rv;
        logic       re;
        logic       rc;
        logic       we;
        logic [1:0] cs;
        logic [1:0] ecc;
    } exp_t;

    localparam int SETUP_N = 1;
    localparam int TURN_N  = 1;
    int         acc_n [2] = '{2, 3};

    exp_t       q [2][$];
    exp_t       cur [2];
    logic [1:0] last_ecc [2];
    int         checks = 0;
    int         errors = 0;
    logic       prev_we [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic ready, input logic rv, input logic re,
                                input logic rc, input logic we, input logic [1:0] cs,
                                input logic [1:0] ecc);
        exp_t v;
        v.ready = ready; v.rv = rv; v.re = re; v.rc = rc;
        v.we = we; v.cs = cs; v.ecc = ecc;
        return v;
    endfunction

    function automatic exp_t reset_vec();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00);
    endfunction

    // Expected cycle-by-cycle outputs for one accepted request.
    task automatic push_txn(input int d, input logic w, input logic [1:0] e);
        if (e == 2'b11) begin
            q[d].push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, last_ecc[d]));
        end else begin
            for (int i = 0; i < SETUP_N; i++)
                q[d].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, ~w, 2'b11, e));
            for (int i = 0; i < acc_n[d]; i++)
                q[d].push_back(mk(1'b0, 1'b0, 1'b0, (!w && i == acc_n[d] - 1), ~w, 2'b00, e));
            for (int i = 0; i < TURN_N; i++)
                q[d].push_back(mk(1'b0, (i == 0), 1'b0, 1'b0, 1'b1, 2'b11, e));
            last_ecc[d] = e;
        end
    endtask

    function automatic exp_t next_exp(input int d);
        if (q[d].size() > 0) return q[d].pop_front();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, last_ecc[d]);
    endfunction

    task automatic check_dut(input int d);
        chk($sformatf("d%0d_ready", d), {7'b0, o_ready[d]}, {7'b0, cur[d].ready});
        chk($sformatf("d%0d_rsp_valid", d), {7'b0, o_rv[d]}, {7'b0, cur[d].rv});
        chk($sformatf("d%0d_rsp_err", d), {7'b0, o_re[d]}, {7'b0, cur[d].re});
        chk($sformatf("d%0d_rd_capture", d), {7'b0, o_rc[d]}, {7'b0, cur[d].rc});
        chk($sformatf("d%0d_write_en", d), {7'b0, o_we[d]}, {7'b0, cur[d].we});
        chk($sformatf("d%0d_chip_sel", d), {6'b0, o_cs[d]}, {6'b0, cur[d].cs});
        chk($sformatf("d%0d_ecc_sel", d), {6'b0, o_ecc[d]}, {6'b0, cur[d].ecc});
    endtask

    // Called at a falling edge: check, drive inputs, advance one cycle.
    task automatic step(input logic r, input logic v, input logic w, input logic [1:0] e);
        for (int d = 0; d < 2; d++) check_dut(d);
        rst_n     = r;
        req_valid = v;
        req_write = w;
        req_ecc   = e;
        for (int d = 0; d < 2; d++)
            if (r && cur[d].ready && v) push_txn(d, w, e);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) cur[d] = r ? next_exp(d) : reset_vec();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    // Pull reset in the middle of an access, between clock edges.
    task automatic mid_access_reset();
        int guard;
        step(1'b1, 1'b1, 1'b1, 2'b01);
        guard = 0;
        while (cur[0].cs != 2'b00 && guard < 10) begin
            step(1'b1, 1'b0, 1'b0, 2'b00);
            guard++;
        end
        chk("in_access_cs", {6'b0, o_cs[0]}, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_async_cs", d), {6'b0, o_cs[d]}, 8'h03);
            chk($sformatf("d%0d_async_we", d), {7'b0, o_we[d]}, 8'h01);
            chk($sformatf("d%0d_async_rv", d), {7'b0, o_rv[d]}, 8'h00);
            chk($sformatf("d%0d_async_ready", d), {7'b0, o_ready[d]}, 8'h00);
            q[d].delete();
            last_ecc[d] = 2'b00;
            cur[d] = reset_vec();
        end
        step(1'b0, 1'b1, 1'b0, 2'b10);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        idle(2);
    endtask

    // Bus contention watch: chip_sel must never be 00 on a cycle where
    // write_en just moved.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n === 1'b1)
                chk($sformatf("d%0d_no_contention", d),
                    {7'b0, (o_cs[d] == 2'b00) && (o_we[d] != prev_we[d])}, 8'h00);
            prev_we[d] = o_we[d];
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_ecc   = 2'b00;
        for (int d = 0; d < 2; d++) begin
            last_ecc[d] = 2'b00;
            cur[d]      = reset_vec();
            prev_we[d]  = 1'b1;
        end
        @(negedge clk);
        // reset held with a request pending: nothing may be taken
        step(1'b0, 1'b1, 1'b1, 2'b01);
        step(1'b0, 1'b1, 1'b1, 2'b01);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        idle(1);

        // write, ecc=01
        step(1'b1, 1'b1, 1'b1, 2'b01);
        idle(6);
        // read, ecc=10 (3-cycle access on the second instance)
        step(1'b1, 1'b1, 1'b0, 2'b10);
        idle(7);
        // illegal ecc code
        step(1'b1, 1'b1, 1'b1, 2'b11);
        idle(3);
        // back-to-back: write then read with req_valid held high
        step(1'b1, 1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 2'b10);
        idle(8);

        mid_access_reset();

        // random traffic, inputs wiggling freely while busy
        for (int i = 0; i < 600; i++)
            step(1'b1, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
